key_scan_encoder: RTL and testbench
===================================

KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000: consecutive stable cycles required to accept a press or release; legal range 2..65535.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 50000: auto-repeat period; only used when REPEAT_EN is defined.
REQ-003 SHALL have a single clock domain and synchronous active-high reset, with port clk input 1 (rising-edge clock).
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port key_n input 8: active-low key lines, asynchronous to clk, bit i low = key i pressed.
REQ-006 SHALL have port code output 3: binary index of the accepted key.
REQ-007 SHALL have port valid output 1: high while the accepted key is debounced-held.
REQ-008 SHALL have port press output 1: one-cycle pulse per accepted press (and per repeat, if enabled).
REQ-009 SHALL have port multi output 1: more than one key line was low in the cycle the press was accepted.

Function
REQ-010 SHALL pass key_n through a two-flop synchronizer (reset value 8'hFF); all logic below uses the synchronized value ks.
REQ-011 SHALL derive candidate index cand = lowest i with ks[i]==0; cand is don't-care when ks==8'hFF.
REQ-012 SHALL implement FSM states IDLE, DB_DOWN, HELD, DB_UP, with a 16-bit counter cnt.
REQ-013 IDLE: ks!=8'hFF -> latch cand into pend, cnt<=0, go DB_DOWN; otherwise stay.
REQ-014 DB_DOWN: ks==8'hFF -> IDLE (bounce rejected, no outputs change).
REQ-015 DB_DOWN: cand!=pend -> pend<=cand, cnt<=0, stay (restart on key change).
REQ-016 DB_DOWN: cnt==DB_CYCLES-1 with cand==pend -> go HELD; code<=pend, valid<=1, press<=1 for one cycle, multi<=(more than one zero in ks); else cnt<=cnt+1.
REQ-017 Latency: key_n stable low from clock edge k gives press high in the cycle after edge k+DB_CYCLES+3.
REQ-018 HELD: ks[code]==1 -> cnt<=0, go DB_UP; presses or releases of other keys are ignored; code/multi hold.
REQ-019 DB_UP: ks[code]==0 -> back to HELD, no press pulse; cnt==DB_CYCLES-1 with ks[code]==1 -> IDLE, valid<=0; else cnt<=cnt+1.
REQ-020 code and multi SHALL retain the last accepted value after release until the next accepted press.
REQ-021 press SHALL never be high for two consecutive cycles.

Reset
REQ-022 rst high at any clock edge, including mid-debounce or HELD, SHALL force: state IDLE, cnt 0, pend 0, synchronizer 8'hFF, code 3'd0, valid 0, press 0, multi 0, repeat counter 0.
REQ-023 A key held through reset deassertion SHALL be debounced from scratch and produce exactly one press.

Configuration
REQ-024 Macro KEY_SCAN_REPEAT_EN defined: in HELD, a repeat counter counts from entry; at REPEAT_CYCLES-1 press pulses one cycle and counter restarts; counter clears on leaving HELD; DB_UP pauses it.
REQ-025 Macro KEY_SCAN_REPEAT_EN undefined: no repeat counter exists; exactly one press per accepted hold.

Verification (DB_CYCLES=4, REPEAT_CYCLES=8)
REQ-026 key_n=8'hFB held 20 cycles -> press one pulse 7 cycles after first low sample, code=3'd2, valid=1, multi=0; release -> valid=0 after 7 cycles, code stays 2.
REQ-027 key_n=8'hFE low 2 cycles, then 8'hFF -> press never pulses, valid stays 0.
REQ-028 key_n=8'h5F (keys 5,7) held -> code=3'd5, multi=1; then key 0 also low while HELD -> code unchanged, no extra press.
REQ-029 Key 3 held; 2-cycle high glitch on bit 3 -> valid stays 1, no second press.
REQ-030 rst asserted one cycle while HELD with key still low -> all outputs 0 next cycle; one new press after re-debounce.
REQ-031 KEY_SCAN_REPEAT_EN defined, key 1 held 40 cycles -> initial press plus repeat press every 8 cycles; undefined -> single press.

Source files
------------

// File: rtl/key_scan_encoder.sv
// Debounced 8-key scanner: synchronizes active-low key lines, accepts the lowest pressed key.
// Optional auto-repeat while held is enabled by defining KEY_SCAN_REPEAT_EN.
module key_scan_encoder #(
  parameter int unsigned DB_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_n,
  output logic [2:0] code,
  output logic       valid,
  output logic       press,
  output logic       multi
);

  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65536)
  begin : g_param_check
    $error("key_scan_encoder: DB_CYCLES or REPEAT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_DOWN = 2'd1,
    HELD    = 2'd2,
    DB_UP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       sync1_q, sync1_d;
  logic [7:0]       ks_q, ks_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pend_q, pend_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             press_q, press_d;
  logic             multi_q, multi_d;
`ifdef KEY_SCAN_REPEAT_EN
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rpt_q, rpt_d;
`endif

  logic [2:0] cand;
  logic [3:0] zero_cnt;

  // Lowest pressed key and number of pressed keys in the synchronized sample.
  always_comb begin
    cand     = 3'd0;
    zero_cnt = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!ks_q[i]) cand = 3'(i);
      zero_cnt = zero_cnt + {3'b000, ~ks_q[i]};
    end
  end

  always_comb begin
    sync1_d = key_n;
    ks_d    = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    code_d  = code_q;
    valid_d = valid_q;
    press_d = 1'b0;
    multi_d = multi_q;
`ifdef KEY_SCAN_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ks_q != 8'hFF) begin
          pend_d  = cand;
          cnt_d   = '0;
          state_d = DB_DOWN;
        end
      end
      DB_DOWN: begin
        if (ks_q == 8'hFF) begin
          state_d = IDLE;
        end else if (cand != pend_q) begin
          pend_d = cand;
          cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          code_d  = pend_q;
          valid_d = 1'b1;
          press_d = 1'b1;
          multi_d = (zero_cnt > 4'd1);
`ifdef KEY_SCAN_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        // Only the accepted key's line matters while held.
        if (ks_q[code_q]) begin
          cnt_d   = '0;
          state_d = DB_UP;
        end
`ifdef KEY_SCAN_REPEAT_EN
        else if (rpt_q == RP_LAST) begin
          press_d = 1'b1;
          rpt_d   = '0;
        end else begin
          rpt_d = rpt_q + CNT_W'(1);
        end
`endif
      end
      DB_UP: begin
        if (!ks_q[code_q]) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          valid_d = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'hFF;
      ks_q    <= 8'hFF;
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 3'd0;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      press_q <= 1'b0;
      multi_q <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      ks_q    <= ks_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      press_q <= press_d;
      multi_q <= multi_d;
`ifdef KEY_SCAN_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign press = press_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Bench for key_scan_encoder: directed scenarios plus random key activity against a run-length model.
module tb_key_scan_encoder;

  localparam int unsigned DB = 4;
  localparam int unsigned RP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_n;
  logic [2:0] code;
  logic       valid, press, multi;

  key_scan_encoder #(.DB_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
    .clk(clk), .rst(rst), .key_n(key_n),
    .code(code), .valid(valid), .press(press), .multi(multi)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a press is accepted after DB+1 consecutive samples with the same
  // lowest pressed key; a release after DB+1 consecutive samples with the held key up.
  logic [7:0] m_s1 = 8'hFF, m_ks = 8'hFF;
  bit         m_held = 0;
  int         m_run = 0, m_rel = 0, m_rpt = 0;
  logic [2:0] m_rc = 3'd0;
  logic [2:0] m_code = 3'd0;
  logic       m_valid = 0, m_press = 0, m_multi = 0;
  logic       prev_press = 0;
  int         press_cnt = 0;

  function automatic int lowest_zero(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (!v[i]) return i;
    return 0;
  endfunction

  function automatic int count_zero(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) if (!v[i]) n++;
    return n;
  endfunction

  task automatic model_step(input logic [7:0] kn, input logic r);
    int c;
    m_press = 0;
    if (r) begin
      m_s1 = 8'hFF; m_ks = 8'hFF; m_held = 0; m_run = 0; m_rel = 0; m_rpt = 0;
      m_code = 3'd0; m_valid = 0; m_multi = 0;
      return;
    end
    if (!m_held) begin
      if (m_ks == 8'hFF) m_run = 0;
      else begin
        c = lowest_zero(m_ks);
        if (m_run > 0 && 3'(c) == m_rc) m_run++;
        else begin m_rc = 3'(c); m_run = 1; end
        if (m_run == DB + 1) begin
          m_held = 1; m_code = m_rc; m_valid = 1; m_press = 1;
          m_multi = (count_zero(m_ks) > 1); m_rel = 0; m_rpt = 0;
        end
      end
    end else begin
      if (m_ks[m_code]) begin
        m_rel++;
        if (m_rel == DB + 1) begin m_held = 0; m_valid = 0; m_run = 0; m_rel = 0; m_rpt = 0; end
      end else begin
`ifdef KEY_SCAN_REPEAT_EN
        if (m_rel == 0) begin
          m_rpt++;
          if (m_rpt == RP) begin m_press = 1; m_rpt = 0; end
        end
`endif
        m_rel = 0;
      end
    end
    m_ks = m_s1;
    m_s1 = kn;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare shortly after.
  task automatic cycle(input logic [7:0] kn, input logic r);
    key_n = kn; rst = r;
    @(posedge clk);
    model_step(kn, r);
    #1;
    chk("code", 32'(code), 32'(m_code));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("press", 32'(press), 32'(m_press));
    chk("multi", 32'(multi), 32'(m_multi));
    chk("press_back_to_back", 32'(press & prev_press), 32'd0);
    prev_press = press;
    if (press) press_cnt++;
  endtask

  initial begin
    int first, p0, exp_rep;
    logic [7:0] pat, kv;
    int len;

    key_n = 8'hFF; rst = 1'b1;
    // Reset state
    for (int i = 0; i < 3; i++) cycle(8'hFF, 1'b1);
    chk("reset_outputs", 32'({code, valid, press, multi}), 32'd0);

    // Key 2 held: latency, code, release timing
    first = -1; p0 = press_cnt;
    for (int i = 1; i <= 20; i++) begin
      cycle(8'hFB, 1'b0);
      if (press && first < 0) first = i;
    end
    chk("k2_press_latency", 32'(first), 32'd7);
    chk("k2_press_count", 32'(press_cnt - p0), 32'd1);
    chk("k2_code", 32'(code), 32'd2);
    chk("k2_multi", 32'(multi), 32'd0);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(8'hFF, 1'b0);
      if (!valid && first < 0) first = i;
    end
    chk("k2_release_latency", 32'(first), 32'd7);
    chk("k2_code_retained", 32'(code), 32'd2);

    // Short bounce rejected
    p0 = press_cnt;
    cycle(8'hFE, 1'b0); cycle(8'hFE, 1'b0);
    for (int i = 0; i < 12; i++) cycle(8'hFF, 1'b0);
    chk("bounce_press_count", 32'(press_cnt - p0), 32'd0);
    chk("bounce_valid", 32'(valid), 32'd0);

    // Keys 5 and 7, then key 0 added while held
    p0 = press_cnt;
    for (int i = 0; i < 12; i++) cycle(8'h5F, 1'b0);
    chk("k57_code", 32'(code), 32'd5);
    chk("k57_multi", 32'(multi), 32'd1);
    for (int i = 0; i < 10; i++) cycle(8'h5E, 1'b0);
    chk("k57_code_hold", 32'(code), 32'd5);
    chk("k57_press_count", 32'(press_cnt - p0), 32'd1);
    for (int i = 0; i < 12; i++) cycle(8'hFF, 1'b0);

    // Key 3 with a 2-cycle release glitch
    p0 = press_cnt;
    for (int i = 0; i < 12; i++) cycle(8'hF7, 1'b0);
    cycle(8'hFF, 1'b0); cycle(8'hFF, 1'b0);
    for (int i = 0; i < 10; i++) cycle(8'hF7, 1'b0);
    chk("glitch_valid", 32'(valid), 32'd1);
    chk("glitch_press_count", 32'(press_cnt - p0), 32'd1);

    // Reset while held, key still down
    cycle(8'hF7, 1'b1);
    chk("rst_held_outputs", 32'({code, valid, press, multi}), 32'd0);
    p0 = press_cnt;
    for (int i = 0; i < 15; i++) cycle(8'hF7, 1'b0);
    chk("rst_redebounce_press", 32'(press_cnt - p0), 32'd1);
    chk("rst_redebounce_code", 32'(code), 32'd3);
    for (int i = 0; i < 12; i++) cycle(8'hFF, 1'b0);

    // Key 1 held 40 cycles: auto-repeat when enabled
    p0 = press_cnt;
    for (int i = 0; i < 40; i++) cycle(8'hFD, 1'b0);
`ifdef KEY_SCAN_REPEAT_EN
    exp_rep = 5;
`else
    exp_rep = 1;
`endif
    chk("k1_hold_press_count", 32'(press_cnt - p0), 32'(exp_rep));
    for (int i = 0; i < 12; i++) cycle(8'hFF, 1'b0);

    // Random key activity with bounces and occasional reset
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin pat = 8'hFF; pat[$urandom_range(0, 7)] = 1'b0; end
        5, 6, 7:       pat = 8'($urandom());
        default:       pat = 8'hFF;
      endcase
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        kv = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : pat;
        cycle(kv, ($urandom_range(0, 99) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
